vx_wb_commit_arb: RTL and testbench
===================================

# vx_wb_commit_arb

Writeback commit arbiter for one issue slice. It merges the writeback streams of the execute units (ALU, LSU, SFU, FPU, …) onto the single writeback channel that feeds the register file and the scoreboard release path. Selection is round-robin with packet locking, so a multi-beat writeback (sop…eop) from one unit is never interleaved with another unit's beats. Output is registered: one beat per cycle, one cycle of latency.

## Interface
- NUM_REQS, default 4: number of execute-unit writeback requesters (≥1).
- DATAW, default 64: payload width per beat (wis, rd, PC, tmask, data, uuid packed by the caller).
- SEL_W, derived: max(1, $clog2(NUM_REQS)).

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQS  per-requester beat valid.
- req_sop  in  NUM_REQS  first beat of packet.
- req_eop  in  NUM_REQS  last beat of packet; the scoreboard releases rd only on eop.
- req_data  in  NUM_REQS×DATAW  per-requester payload.
- req_ready  out  NUM_REQS  beat accepted when valid && ready.
- wb_valid  out  1  output beat valid.
- wb_sop  out  1  registered sop of the output beat.
- wb_eop  out  1  registered eop of the output beat.
- wb_data  out  DATAW  registered payload.
- wb_sel  out  SEL_W  index of the requester that produced the output beat.
- wb_ready  in  1  downstream ready.
- lock_active  out  1  high while a packet is mid-flight (locked to one requester).

## Operation
- **State:** rr_ptr (SEL_W bits), lock (1 bit), lock_idx (SEL_W bits), plus the output register (valid, sop, eop, data, sel).
- **Load condition:** can_load = ~wb_valid | wb_ready.
- **Unlocked grant:** the requester granted is the first valid one found scanning cyclically from rr_ptr: rr_ptr, rr_ptr+1, … mod NUM_REQS. Exactly one requester, or none, is granted per cycle.
- **Locked grant:** only lock_idx can be granted. Every other req_ready is 0, even when lock_idx is not valid; that cycle is a bubble.
- **Ready:** req_ready[g] = grant[g] && can_load. All other req_ready bits are 0.
- **Accept:** on an accepted beat from g, the output register loads {sop, eop, data, g} and wb_valid goes to 1. When can_load is true and nothing is accepted, wb_valid goes to 0. When can_load is false, the output register holds.
- **Lock set:** an accepted beat with eop=0 sets lock=1 and lock_idx=g.
- **Lock clear:** an accepted beat with eop=1 sets lock=0. A single-beat packet (sop=eop=1) never sets lock.
- **Pointer update:** rr_ptr ← (g+1) mod NUM_REQS only when an eop beat is accepted. Non-eop beats and idle cycles leave rr_ptr unchanged.
- **NUM_REQS=1:** always grant 0; rr_ptr stays 0; the lock logic is still present.
- **Simulation assertions:**
  - An accepted unlocked beat must have sop=1.
  - An accepted locked beat must have sop=0.
  - wb_data, wb_sel, wb_sop and wb_eop stay stable while wb_valid && ~wb_ready.
- **Reset:**
  - wb_valid=0, lock=0, lock_active=0, rr_ptr=0.
  - wb_sop, wb_eop, wb_data and wb_sel are don't-care while wb_valid=0.
  - Reset mid-packet discards the lock and any held beat; the partial packet is not completed.

## Timing
- Latency: an accepted beat appears on wb_* on the next cycle.
- Throughput: 1 beat/cycle sustained when wb_ready=1, including back-to-back packets from different requesters with no bubble.
- Combinational paths:
  - wb_ready → req_ready: one AND level.
  - req_valid → req_ready: through the priority scan.
  - No combinational path from any req_* input to any wb_* output.
- lock_active is the registered lock bit. It rises the cycle after the accept of a non-eop beat and falls the cycle after the accept of the eop beat.
- **Simultaneous events:** when wb_ready=1 and a new grant happen in the same cycle, the current beat drains and the new beat loads with no gap.

## Test plan
1. **Round-robin rotation:** after reset, all 4 requesters issue continuous single-beat packets (sop=eop=1) with wb_ready=1 → wb_sel sequence 0,1,2,3,0,1…; first wb_valid appears 1 cycle after the first accept.
2. **Packet lock:** req1 sends a 3-beat packet (sop,–,eop) while req0, req2 and req3 stay valid → the three req1 beats appear contiguously on wb_sel=1; the next grant goes to req2; lock_active is high for exactly 2 cycles.
3. **Bubble while locked:** req1 deasserts valid for 2 cycles mid-packet while req0 is valid → req_ready[0]=0 throughout; wb_valid=0 for those 2 cycles; the packet then completes on req1.
4. **Backpressure:** wb_ready=0 for 5 cycles with a beat held → wb_data and wb_sel are stable, all req_ready=0, and no beat is lost or duplicated once wb_ready returns to 1.
5. **Reset mid-packet:** reset asserted after the 2nd beat of a 4-beat packet → next cycle wb_valid=0, lock_active=0, rr_ptr=0; the first post-reset grant follows pointer 0.
6. **Single requester (NUM_REQS=1):** 100 random beats with random wb_ready → output matches input order exactly and wb_sel is always 0.

Source files
------------

// File: rtl/vx_wb_commit_arb.sv
// vx_wb_commit_arb
// Writeback commit arbiter for one issue slice. Merges the per-unit
// writeback beat streams onto a single registered writeback channel.
// Unlocked grants rotate round-robin from rr_ptr. Once a packet's first
// beat is taken, the arbiter locks to that requester until its eop beat
// is accepted, so multi-beat packets are never interleaved.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   req_valid     per-requester beat valid
//   req_sop       per-requester first-beat flag
//   req_eop       per-requester last-beat flag
//   req_data      per-requester payload, requester r at [r*DATAW +: DATAW]
//   req_ready     per-requester accept (valid && ready = beat taken)
//   wb_valid      registered output beat valid
//   wb_sop        registered sop of the output beat
//   wb_eop        registered eop of the output beat
//   wb_data       registered payload
//   wb_sel        index of the requester that produced the output beat
//   wb_ready      downstream ready
//   lock_active   high while a packet is mid-flight
module vx_wb_commit_arb #(
  parameter int NUM_REQS = 4,
  parameter int DATAW = 64,
  localparam int SEL_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS-1:0]       req_sop,
  input  logic [NUM_REQS-1:0]       req_eop,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      wb_valid,
  output logic                      wb_sop,
  output logic                      wb_eop,
  output logic [DATAW-1:0]          wb_data,
  output logic [SEL_W-1:0]          wb_sel,
  input  logic                      wb_ready,
  output logic                      lock_active
);

  localparam logic [SEL_W:0]   NUM_REQS_W = (SEL_W+1)'(NUM_REQS);
  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_REQS - 1);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] lock_idx;
  logic             lock;

  logic             grant_found;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W:0]   cand;
  logic [SEL_W-1:0] cand_idx;
  logic [SEL_W-1:0] next_ptr;
  logic             can_load;
  logic             accept;
  logic             sel_sop;
  logic             sel_eop;
  logic [DATAW-1:0] sel_data;

  // Grant selection. While locked only the lock owner may be granted, and
  // an idle owner produces a bubble rather than letting anyone else in.
  // Unlocked, scan cyclically from rr_ptr; the index is kept one bit wider
  // so the wrap works for non-power-of-two requester counts.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    cand_idx    = '0;
    if (lock) begin
      grant_found = req_valid[lock_idx];
      grant_idx   = lock_idx;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        cand = {1'b0, rr_ptr} + (SEL_W+1)'(i);
        if (cand >= NUM_REQS_W) cand = cand - NUM_REQS_W;
        cand_idx = cand[SEL_W-1:0];
        if (!grant_found && req_valid[cand_idx]) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  assign can_load = ~wb_valid | wb_ready;
  assign accept   = grant_found & can_load;
  assign sel_sop  = req_sop[grant_idx];
  assign sel_eop  = req_eop[grant_idx];
  assign sel_data = req_data[grant_idx*DATAW +: DATAW];
  assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  // Only the granted requester sees ready, and only when the output
  // register can take a beat this cycle.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // Control state. The pointer only advances on packet completion so a
  // multi-beat packet counts as a single round-robin turn.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      lock     <= 1'b0;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else begin
      if (can_load) wb_valid <= accept;
      if (accept) begin
        if (sel_eop) begin
          lock   <= 1'b0;
          rr_ptr <= next_ptr;
        end else begin
          lock     <= 1'b1;
          lock_idx <= grant_idx;
        end
      end
    end
  end

  // Output payload register. Left unreset: its contents only matter
  // while wb_valid is high, which reset clears.
  always_ff @(posedge clk) begin
    if (accept) begin
      wb_sop  <= sel_sop;
      wb_eop  <= sel_eop;
      wb_data <= sel_data;
      wb_sel  <= grant_idx;
    end
  end

  assign lock_active = lock;

`ifndef SYNTHESIS
  unlocked_beat_has_sop: assert property (@(posedge clk) disable iff (reset)
    (accept && !lock) |-> sel_sop);
  locked_beat_has_no_sop: assert property (@(posedge clk) disable iff (reset)
    (accept && lock) |-> !sel_sop);
  held_beat_stable: assert property (@(posedge clk) disable iff (reset)
    (wb_valid && !wb_ready) |=> ($stable(wb_data) && $stable(wb_sel) &&
                                 $stable(wb_sop) && $stable(wb_eop)));
`endif

endmodule

// File: tb/tb_vx_wb_commit_arb.sv
module tb_vx_wb_commit_arb;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = 2;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    req_valid, req_sop, req_eop, req_ready;
  logic [N*DW-1:0] req_data;
  logic            wb_valid, wb_sop, wb_eop, wb_ready, lock_active;
  logic [DW-1:0]   wb_data;
  logic [SW-1:0]   wb_sel;

  logic            u_valid, u_sop, u_eop, u_ready;
  logic [DW-1:0]   u_data, u_wb_data;
  logic            u_wb_valid, u_wb_sop, u_wb_eop, u_wb_ready, u_lock;
  logic [0:0]      u_wb_sel;

  vx_wb_commit_arb #(.NUM_REQS(N), .DATAW(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_sop(req_sop), .req_eop(req_eop),
    .req_data(req_data), .req_ready(req_ready),
    .wb_valid(wb_valid), .wb_sop(wb_sop), .wb_eop(wb_eop),
    .wb_data(wb_data), .wb_sel(wb_sel), .wb_ready(wb_ready),
    .lock_active(lock_active)
  );

  vx_wb_commit_arb #(.NUM_REQS(1), .DATAW(DW)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(u_valid), .req_sop(u_sop), .req_eop(u_eop),
    .req_data(u_data), .req_ready(u_ready),
    .wb_valid(u_wb_valid), .wb_sop(u_wb_sop), .wb_eop(u_wb_eop),
    .wb_data(u_wb_data), .wb_sel(u_wb_sel), .wb_ready(u_wb_ready),
    .lock_active(u_lock)
  );

  int checks = 0;
  int passes = 0;
  int seq_id = 0;

  // Pending beats of each requester, in issue order
  beat_t srcq [N][$];
  beat_t u_q [$];

  // Reference model: the beat the output register must hold, packet
  // ownership and the round-robin starting point
  bit            e_valid, e_sop, e_eop, e_lock;
  logic [DW-1:0] e_data;
  int            e_sel, e_owner, e_ptr;
  logic [N-1:0]  e_ready;

  // Per-cycle observations for the directed scenarios
  int            cyc;
  bit            obs_valid [64];
  int            obs_sel   [64];
  logic [DW-1:0] obs_data  [64];
  logic [N-1:0]  obs_ready [64];
  bit            obs_lock  [64];

  task automatic tally(input bit ok, input string msg);
    checks++;
    if (ok) passes++;
    else $display("[TB] FAIL %s", msg);
  endtask

  task automatic addPacket(input int r, input int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.sop  = (b == 0);
      bt.eop  = (b == len - 1);
      bt.data = {8'(r), 24'(seq_id), 32'($urandom)};
      seq_id++;
      srcq[r].push_back(bt);
    end
  endtask

  task automatic resetDut();
    reset      = 1'b1;
    req_valid  = '0; req_sop = '0; req_eop = '0; req_data = '0;
    wb_ready   = 1'b1;
    u_valid    = 1'b0; u_sop = 1'b0; u_eop = 1'b0; u_data = '0;
    u_wb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tally(wb_valid === 1'b0 && lock_active === 1'b0,
          $sformatf("reset got wb_valid=%b lock_active=%b, exp 0 0", wb_valid, lock_active));
    tally(u_wb_valid === 1'b0 && u_lock === 1'b0,
          $sformatf("reset1 got wb_valid=%b lock_active=%b, exp 0 0", u_wb_valid, u_lock));
    reset   = 1'b0;
    e_valid = 0; e_lock = 0; e_ptr = 0; e_owner = 0;
    // a packet cut short by reset is abandoned by its source
    for (int r = 0; r < N; r++)
      while (srcq[r].size() > 0 && srcq[r][0].sop == 1'b0) void'(srcq[r].pop_front());
    cyc = 0;
  endtask

  task automatic checkOutput();
    bit ok;
    ok = (wb_valid === e_valid) && (lock_active === e_lock);
    if (e_valid)
      ok = ok && (wb_sop === e_sop) && (wb_eop === e_eop) &&
           (wb_data === e_data) && (wb_sel === SW'(e_sel));
    tally(ok, $sformatf("out cyc%0d got v=%b sop=%b eop=%b sel=%0d d=%h lock=%b, exp v=%b sop=%b eop=%b sel=%0d d=%h lock=%b",
          cyc, wb_valid, wb_sop, wb_eop, wb_sel, wb_data, lock_active,
          e_valid, e_sop, e_eop, e_sel, e_data, e_lock));
    if (cyc < 64) begin
      obs_valid[cyc] = wb_valid;
      obs_sel[cyc]   = int'(wb_sel);
      obs_data[cyc]  = wb_data;
      obs_lock[cyc]  = lock_active;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] gate, input int vpct, input int rpct);
    for (int r = 0; r < N; r++) begin
      if (gate[r] && srcq[r].size() > 0 && $urandom_range(99) < vpct) begin
        req_valid[r]           = 1'b1;
        req_sop[r]             = srcq[r][0].sop;
        req_eop[r]             = srcq[r][0].eop;
        req_data[r*DW +: DW]   = srcq[r][0].data;
      end else begin
        req_valid[r]           = 1'b0;
        req_sop[r]             = 1'b0;
        req_eop[r]             = 1'b0;
        req_data[r*DW +: DW]   = '0;
      end
    end
    wb_ready = ($urandom_range(99) < rpct);
  endtask

  // Decide this cycle's winner from the arbitration rules and advance
  // the model to what the DUT must show after the coming edge.
  task automatic modelStep();
    int w;
    bit can;
    beat_t bt;
    can = !e_valid || wb_ready;
    w = -1;
    if (e_lock) begin
      if (req_valid[e_owner]) w = e_owner;
    end else begin
      for (int i = 0; i < N; i++)
        if (w < 0 && req_valid[(e_ptr + i) % N]) w = (e_ptr + i) % N;
    end
    e_ready = '0;
    if (w >= 0 && can) e_ready[w] = 1'b1;
    tally(req_ready === e_ready,
          $sformatf("ready cyc%0d got %b, exp %b", cyc, req_ready, e_ready));
    if (cyc < 64) obs_ready[cyc] = req_ready;
    if (can) begin
      e_valid = (w >= 0);
      if (w >= 0) begin
        bt     = srcq[w].pop_front();
        e_sop  = bt.sop;
        e_eop  = bt.eop;
        e_data = bt.data;
        e_sel  = w;
        if (bt.eop) begin
          e_lock = 0;
          e_ptr  = (w + 1) % N;
        end else begin
          e_lock  = 1;
          e_owner = w;
        end
      end
    end
  endtask

  task automatic runCycle(input logic [N-1:0] gate, input int vpct, input int rpct);
    checkOutput();
    applyStimulus(gate, vpct, rpct);
    #1;
    modelStep();
    cyc++;
    @(negedge clk);
  endtask

  task automatic expectBeat(input string name, input int k, input int sel);
    tally(obs_valid[k] && obs_sel[k] == sel,
          $sformatf("%s obs%0d got v=%b sel=%0d, exp v=1 sel=%0d", name, k, obs_valid[k], obs_sel[k], sel));
  endtask

  task automatic expectIdle(input string name, input int k);
    tally(!obs_valid[k], $sformatf("%s obs%0d got v=%b, exp v=0", name, k, obs_valid[k]));
  endtask

  task automatic checkDrained(input string name);
    int left;
    left = 0;
    for (int r = 0; r < N; r++) left += srcq[r].size();
    tally(left == 0, $sformatf("%s drain got %0d beats left, exp 0", name, left));
  endtask

  // Single-requester instance: beats must come out in issue order on sel 0
  task automatic runSingle();
    beat_t bt;
    bit ue_valid, ue_sop, ue_eop, ue_lock, can, ok;
    logic [DW-1:0] ue_data;
    int delivered, left, len;
    left = 100;
    while (left > 0) begin
      len = $urandom_range(1, 4);
      if (len > left) len = left;
      for (int b = 0; b < len; b++) begin
        bt.sop = (b == 0); bt.eop = (b == len - 1);
        bt.data = {8'hA5, 24'(seq_id), 32'($urandom)};
        seq_id++;
        u_q.push_back(bt);
      end
      left -= len;
    end
    ue_valid = 0; ue_sop = 0; ue_eop = 0; ue_lock = 0; ue_data = '0;
    delivered = 0;
    for (int c = 0; c < 1000 && delivered < 100; c++) begin
      ok = (u_wb_valid === ue_valid) && (u_lock === ue_lock);
      if (ue_valid)
        ok = ok && (u_wb_sop === ue_sop) && (u_wb_eop === ue_eop) &&
             (u_wb_data === ue_data) && (u_wb_sel === 1'b0);
      tally(ok, $sformatf("single out c%0d got v=%b sel=%0d d=%h lock=%b, exp v=%b sel=0 d=%h lock=%b",
            c, u_wb_valid, u_wb_sel, u_wb_data, u_lock, ue_valid, ue_data, ue_lock));
      if (u_q.size() > 0 && $urandom_range(99) < 70) begin
        u_valid = 1'b1; u_sop = u_q[0].sop; u_eop = u_q[0].eop; u_data = u_q[0].data;
      end else begin
        u_valid = 1'b0; u_sop = 1'b0; u_eop = 1'b0; u_data = '0;
      end
      u_wb_ready = ($urandom_range(99) < 60);
      #1;
      can = !ue_valid || u_wb_ready;
      tally(u_ready === (u_valid && can),
            $sformatf("single ready c%0d got %b, exp %b", c, u_ready, u_valid && can));
      if (ue_valid && u_wb_ready) delivered++;
      if (can) begin
        ue_valid = u_valid;
        if (u_valid) begin
          bt = u_q.pop_front();
          ue_sop = bt.sop; ue_eop = bt.eop; ue_data = bt.data;
          ue_lock = !bt.eop;
        end
      end
      @(negedge clk);
    end
    tally(delivered == 100, $sformatf("single delivered got %0d, exp 100", delivered));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] held;
    int highs;
    bit drained;

    // Round-robin rotation with single-beat packets everywhere
    resetDut();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 3; k++) addPacket(r, 1);
    for (int k = 0; k < 16; k++) runCycle(4'hF, 100, 100);
    expectIdle("rotate", 0);
    for (int k = 1; k <= 12; k++) expectBeat("rotate", k, (k - 1) % 4);
    checkDrained("rotate");

    // Packet lock: req1's three beats stay together, then req2 is next
    resetDut();
    addPacket(0, 1); addPacket(1, 3); addPacket(2, 1); addPacket(3, 1); addPacket(0, 1);
    for (int k = 0; k < 10; k++) runCycle(4'hF, 100, 100);
    expectBeat("lock", 1, 0);
    expectBeat("lock", 2, 1);
    expectBeat("lock", 3, 1);
    expectBeat("lock", 4, 1);
    expectBeat("lock", 5, 2);
    expectBeat("lock", 6, 3);
    expectBeat("lock", 7, 0);
    highs = 0;
    for (int k = 0; k < 10; k++) highs += int'(obs_lock[k]);
    tally(highs == 2, $sformatf("lock high cycles got %0d, exp 2", highs));
    checkDrained("lock");

    // Bubble while the lock owner goes idle mid-packet
    resetDut();
    addPacket(1, 3); addPacket(0, 1);
    for (int k = 0; k < 8; k++)
      runCycle((k == 0) ? 4'b0010 : (k < 3) ? 4'b0001 : 4'b0011, 100, 100);
    expectBeat("bubble", 1, 1);
    expectIdle("bubble", 2);
    expectIdle("bubble", 3);
    expectBeat("bubble", 4, 1);
    expectBeat("bubble", 5, 1);
    expectBeat("bubble", 6, 0);
    tally(obs_ready[1] == 4'b0000 && obs_ready[2] == 4'b0000,
          $sformatf("bubble ready got %b %b, exp 0000 0000", obs_ready[1], obs_ready[2]));
    checkDrained("bubble");

    // Backpressure: held beat stays put, nothing is taken meanwhile
    resetDut();
    addPacket(0, 1); addPacket(1, 1); addPacket(2, 1);
    held = srcq[0][0].data;
    for (int k = 0; k < 10; k++) runCycle(4'hF, 100, (k >= 1 && k <= 5) ? 0 : 100);
    for (int k = 1; k <= 6; k++) begin
      expectBeat("bp", k, 0);
      tally(obs_data[k] === held, $sformatf("bp data obs%0d got %h, exp %h", k, obs_data[k], held));
    end
    for (int k = 1; k <= 5; k++)
      tally(obs_ready[k] == 4'b0000, $sformatf("bp ready obs%0d got %b, exp 0000", k, obs_ready[k]));
    expectBeat("bp", 7, 1);
    expectBeat("bp", 8, 2);
    checkDrained("bp");

    // Reset in the middle of a 4-beat packet
    resetDut();
    addPacket(0, 1); addPacket(2, 4);
    for (int k = 0; k < 3; k++) runCycle(4'hF, 100, 100);
    tally(lock_active === 1'b1, $sformatf("midpkt lock got %b, exp 1", lock_active));
    resetDut();
    for (int r = 0; r < N; r++) addPacket(r, 1);
    for (int k = 0; k < 6; k++) runCycle(4'hF, 100, 100);
    expectBeat("postreset", 1, 0);
    expectBeat("postreset", 2, 1);
    checkDrained("postreset");

    // Random traffic against the model
    resetDut();
    for (int p = 0; p < 120; p++) addPacket($urandom_range(0, N - 1), $urandom_range(1, 4));
    drained = 0;
    for (int k = 0; k < 4000 && !drained; k++) begin
      runCycle(4'hF, 70, 65);
      drained = !e_valid;
      for (int r = 0; r < N; r++) if (srcq[r].size() > 0) drained = 0;
    end
    checkOutput();
    checkDrained("random");

    // Single requester instance
    resetDut();
    runSingle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
